// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file widths and arbiter FSM encoding
package cpu_pkg;
    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 8;
    localparam int NUM_REGS   = 8;

    localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with last-winner pointer
module rr_arbiter2 (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    // 1 means requester 1 won most recently, so requester 0 wins the first tie
    logic last_gnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_gnt <= 1'b1;
        end else if (advance) begin
            last_gnt <= gnt[1];
        end
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: rtl/regwrite_arbiter.sv
// rtl/regwrite_arbiter.sv - arbitrates two register-write requesters and sweeps a clear
module regwrite_arbiter
    import cpu_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ0_VALID,
    input  logic [REG_ADDR_W-1:0] REQ0_ADDR,
    input  logic [REG_DATA_W-1:0] REQ0_DATA,
    output logic                  REQ0_READY,
    input  logic                  REQ1_VALID,
    input  logic [REG_ADDR_W-1:0] REQ1_ADDR,
    input  logic [REG_DATA_W-1:0] REQ1_DATA,
    output logic                  REQ1_READY,
    input  logic                  CLR_START,
    output logic                  CLR_DONE,
    output logic                  WRITEENABLE,
    output logic [REG_ADDR_W-1:0] WRITEREG,
    output logic [REG_DATA_W-1:0] WRITEDATA,
    output logic                  BUSY
);
    arb_state_t            state, state_nxt;
    logic [REG_ADDR_W-1:0] clr_cnt, clr_cnt_nxt, wreg_nxt;
    logic [REG_DATA_W-1:0] wdata_nxt;
    logic                  we_nxt, done_nxt;
    logic                  arb_open;
    logic [1:0]            req, gnt;

    assign arb_open = (state == ST_ARB) && !CLR_START;
    assign req      = {REQ1_VALID, REQ0_VALID} & {2{arb_open}};

    rr_arbiter2 u_rr (
        .CLK     (CLK),
        .RESET   (RESET),
        .req     (req),
        .advance (|gnt),
        .gnt     (gnt)
    );

    assign REQ0_READY = gnt[0];
    assign REQ1_READY = gnt[1];
    assign BUSY       = (state == ST_CLEAR);

    // The write registers are loaded one step ahead so each CLEAR cycle already shows its own index
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        we_nxt      = 1'b0;
        wreg_nxt    = WRITEREG;
        wdata_nxt   = WRITEDATA;
        done_nxt    = 1'b0;
        case (state)
            ST_ARB: begin
                if (CLR_START) begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = '0;
                    we_nxt      = 1'b1;
                    wreg_nxt    = '0;
                    wdata_nxt   = '0;
                end else if (gnt[0]) begin
                    we_nxt    = 1'b1;
                    wreg_nxt  = REQ0_ADDR;
                    wdata_nxt = REQ0_DATA;
                end else if (gnt[1]) begin
                    we_nxt    = 1'b1;
                    wreg_nxt  = REQ1_ADDR;
                    wdata_nxt = REQ1_DATA;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt == LAST_REG) begin
                    state_nxt   = ST_ARB;
                    clr_cnt_nxt = '0;
                    done_nxt    = 1'b1;
                end else begin
                    clr_cnt_nxt = clr_cnt + REG_ADDR_W'(1);
                    we_nxt      = 1'b1;
                    wreg_nxt    = clr_cnt + REG_ADDR_W'(1);
                    wdata_nxt   = '0;
                end
            end
            default: state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= ST_ARB;
            clr_cnt     <= '0;
            WRITEENABLE <= 1'b0;
            WRITEREG    <= '0;
            WRITEDATA   <= '0;
            CLR_DONE    <= 1'b0;
        end else begin
            state       <= state_nxt;
            clr_cnt     <= clr_cnt_nxt;
            WRITEENABLE <= we_nxt;
            WRITEREG    <= wreg_nxt;
            WRITEDATA   <= wdata_nxt;
            CLR_DONE    <= done_nxt;
        end
    end
endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb/tb_regwrite_arbiter.sv - self-checking bench with behavioural model of regwrite_arbiter
module tb_regwrite_arbiter;
    logic       CLK, RESET;
    logic       REQ0_VALID, REQ1_VALID, REQ0_READY, REQ1_READY;
    logic [2:0] REQ0_ADDR, REQ1_ADDR, WRITEREG;
    logic [7:0] REQ0_DATA, REQ1_DATA, WRITEDATA;
    logic       CLR_START, CLR_DONE, WRITEENABLE, BUSY;

    int vectors = 0;
    int miscompares = 0;

    // behavioural model: expected outputs for the current cycle plus pending clear addresses
    logic       m_last, m_we, m_busy, m_done, m_r0, m_r1;
    logic [2:0] m_reg;
    logic [7:0] m_data;
    logic [2:0] clr_q[$];
    logic [7:0] m_regs[8];
    logic       obs_r0, obs_r1;
    logic [7:0] tb_regs[8];

    regwrite_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
        .CLR_START(CLR_START), .CLR_DONE(CLR_DONE),
        .WRITEENABLE(WRITEENABLE), .WRITEREG(WRITEREG), .WRITEDATA(WRITEDATA), .BUSY(BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) tb_regs[i] <= 8'h00;
        end else if (WRITEENABLE) begin
            tb_regs[WRITEREG] <= WRITEDATA;
        end
    end

    task automatic model_reset();
        m_last = 1'b1; m_we = 1'b0; m_reg = 3'd0; m_data = 8'd0;
        m_busy = 1'b0; m_done = 1'b0;
        clr_q.delete();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    endtask

    task automatic drive_idle();
        REQ0_VALID = 1'b0; REQ0_ADDR = 3'd0; REQ0_DATA = 8'd0;
        REQ1_VALID = 1'b0; REQ1_ADDR = 3'd0; REQ1_DATA = 8'd0;
        CLR_START = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        drive_idle();
        #1;
        vectors++; if (WRITEENABLE !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b expected 0", WRITEENABLE); end
        vectors++; if (WRITEREG !== 3'd0) begin miscompares++; $display("FAIL reset_writereg: got %0d expected 0", WRITEREG); end
        vectors++; if (WRITEDATA !== 8'd0) begin miscompares++; $display("FAIL reset_writedata: got %0d expected 0", WRITEDATA); end
        vectors++; if (CLR_DONE !== 1'b0) begin miscompares++; $display("FAIL reset_clr_done: got %b expected 0", CLR_DONE); end
        vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    // one clock cycle: drive, check grants, predict and check the registered outputs
    task automatic cycle(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                         input logic v1, input logic [2:0] a1, input logic [7:0] d1,
                         input logic clr);
        int win;
        REQ0_VALID = v0; REQ0_ADDR = a0; REQ0_DATA = d0;
        REQ1_VALID = v1; REQ1_ADDR = a1; REQ1_DATA = d1;
        CLR_START = clr;
        #1;
        if (m_we) m_regs[m_reg] = m_data;
        win = -1;
        if (!m_busy && !clr) begin
            if (v0 && v1) win = m_last ? 0 : 1;
            else if (v0)  win = 0;
            else if (v1)  win = 1;
        end
        m_r0 = (win == 0);
        m_r1 = (win == 1);
        obs_r0 = REQ0_READY;
        obs_r1 = REQ1_READY;
        vectors++; if (REQ0_READY !== m_r0) begin miscompares++; $display("FAIL ready0 @%0t: got %b expected %b", $time, REQ0_READY, m_r0); end
        vectors++; if (REQ1_READY !== m_r1) begin miscompares++; $display("FAIL ready1 @%0t: got %b expected %b", $time, REQ1_READY, m_r1); end
        m_done = 1'b0;
        if (m_busy) begin
            if (clr_q.size() > 0) begin
                m_we = 1'b1; m_reg = clr_q.pop_front(); m_data = 8'd0;
            end else begin
                m_we = 1'b0; m_busy = 1'b0; m_done = 1'b1;
            end
        end else if (clr) begin
            for (int i = 1; i < 8; i++) clr_q.push_back(3'(i));
            m_we = 1'b1; m_reg = 3'd0; m_data = 8'd0; m_busy = 1'b1;
        end else if (win == 0) begin
            m_we = 1'b1; m_reg = a0; m_data = d0; m_last = 1'b0;
        end else if (win == 1) begin
            m_we = 1'b1; m_reg = a1; m_data = d1; m_last = 1'b1;
        end else begin
            m_we = 1'b0;
        end
        @(posedge CLK);
        #1;
        vectors++; if (WRITEENABLE !== m_we) begin miscompares++; $display("FAIL we @%0t: got %b expected %b", $time, WRITEENABLE, m_we); end
        vectors++; if (WRITEREG !== m_reg) begin miscompares++; $display("FAIL writereg @%0t: got %0d expected %0d", $time, WRITEREG, m_reg); end
        vectors++; if (WRITEDATA !== m_data) begin miscompares++; $display("FAIL writedata @%0t: got %0d expected %0d", $time, WRITEDATA, m_data); end
        vectors++; if (BUSY !== m_busy) begin miscompares++; $display("FAIL busy @%0t: got %b expected %b", $time, BUSY, m_busy); end
        vectors++; if (CLR_DONE !== m_done) begin miscompares++; $display("FAIL clr_done @%0t: got %b expected %b", $time, CLR_DONE, m_done); end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_single_write();
        do_reset();
        cycle(1'b1, 3'd2, 8'd95, 1'b0, 3'd0, 8'd0, 1'b0);
        vectors++; if (obs_r0 !== 1'b1) begin miscompares++; $display("FAIL single_ready0: got %b expected 1", obs_r0); end
        vectors++; if (WRITEENABLE !== 1'b1 || WRITEREG !== 3'd2 || WRITEDATA !== 8'd95) begin
            miscompares++; $display("FAIL single_strobe: got we=%b reg=%0d data=%0d expected we=1 reg=2 data=95", WRITEENABLE, WRITEREG, WRITEDATA);
        end
        cycle(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0);
        vectors++; if (tb_regs[2] !== 8'd95) begin miscompares++; $display("FAIL single_reg2: got %0d expected 95", tb_regs[2]); end
    endtask

    task automatic test_contention();
        int we_cnt = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 3'd1, 8'd28, 1'b1, 3'd4, 8'd6, 1'b0);
            vectors++; if ({obs_r1, obs_r0} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                miscompares++; $display("FAIL contention_grant%0d: got %b%b expected %s", i, obs_r1, obs_r0, (i % 2 == 0) ? "01" : "10");
            end
            if (WRITEENABLE) we_cnt++;
        end
        vectors++; if (we_cnt != 4) begin miscompares++; $display("FAIL contention_we_count: got %0d expected 4", we_cnt); end
    endtask

    task automatic test_same_addr();
        do_reset();
        cycle(1'b1, 3'd3, 8'd15, 1'b1, 3'd3, 8'd50, 1'b0);
        vectors++; if (WRITEDATA !== 8'd15) begin miscompares++; $display("FAIL same_addr_first: got %0d expected 15", WRITEDATA); end
        cycle(1'b0, 3'd0, 8'd0, 1'b1, 3'd3, 8'd50, 1'b0);
        vectors++; if (WRITEDATA !== 8'd50) begin miscompares++; $display("FAIL same_addr_second: got %0d expected 50", WRITEDATA); end
        cycle(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0);
        vectors++; if (tb_regs[3] !== 8'd50) begin miscompares++; $display("FAIL same_addr_final: got %0d expected 50", tb_regs[3]); end
    endtask

    task automatic test_clear();
        int writes = 0, dones = 0;
        logic granted = 1'b0;
        cycle(1'b1, 3'd6, 8'h3c, 1'b0, 3'd0, 8'd0, 1'b0);
        cycle(1'b0, 3'd0, 8'd0, 1'b1, 3'd5, 8'd77, 1'b1);
        vectors++; if (obs_r1 !== 1'b0) begin miscompares++; $display("FAIL clear_ready1_blocked: got %b expected 0", obs_r1); end
        if (WRITEENABLE && BUSY) writes++;
        for (int k = 0; k < 14 && !granted; k++) begin
            cycle(1'b0, 3'd0, 8'd0, 1'b1, 3'd5, 8'd77, 1'b0);
            if (obs_r1) granted = 1'b1;
            if (WRITEENABLE && BUSY) writes++;
            if (CLR_DONE) dones++;
        end
        vectors++; if (writes != 8) begin miscompares++; $display("FAIL clear_writes: got %0d expected 8", writes); end
        vectors++; if (dones != 1) begin miscompares++; $display("FAIL clear_done_count: got %0d expected 1", dones); end
        vectors++; if (granted !== 1'b1) begin miscompares++; $display("FAIL clear_req1_granted: got %b expected 1", granted); end
        cycle(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0);
        vectors++; if (tb_regs[6] !== 8'd0 || tb_regs[5] !== 8'd77) begin
            miscompares++; $display("FAIL clear_regs: got r6=%0d r5=%0d expected r6=0 r5=77", tb_regs[6], tb_regs[5]);
        end
    endtask

    task automatic test_clear_reset();
        int dones = 0;
        logic found = 1'b0;
        cycle(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b1);
        for (int k = 0; k < 12 && !found; k++) begin
            if (BUSY && WRITEREG == 3'd3) found = 1'b1;
            else cycle(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0);
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL clear_reset_reach3: got no reg-3 clear write expected one within 12 cycles"); end
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0);
            if (CLR_DONE) dones++;
        end
        vectors++; if (dones != 0) begin miscompares++; $display("FAIL clear_reset_no_done: got %0d expected 0", dones); end
        cycle(1'b1, 3'd1, 8'd1, 1'b1, 3'd2, 8'd2, 1'b0);
        vectors++; if (obs_r0 !== 1'b1) begin miscompares++; $display("FAIL clear_reset_first_tie: got ready0=%b expected 1", obs_r0); end
    endtask

    task automatic test_clear_restart();
        int writes = 0, dones = 0;
        do_reset();
        cycle(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b1);
        if (WRITEENABLE && BUSY) writes++;
        for (int k = 0; k < 12; k++) begin
            cycle(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, (k == 2 || k == 5));
            if (WRITEENABLE && BUSY) writes++;
            if (CLR_DONE) dones++;
        end
        vectors++; if (writes != 8) begin miscompares++; $display("FAIL restart_writes: got %0d expected 8", writes); end
        vectors++; if (dones != 1) begin miscompares++; $display("FAIL restart_done_count: got %0d expected 1", dones); end
    endtask

    task automatic test_random();
        logic       p0v = 1'b0, p1v = 1'b0;
        logic [2:0] p0a = 3'd0, p1a = 3'd0;
        logic [7:0] p0d = 8'd0, p1d = 8'd0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (!p0v && $urandom_range(0, 2) == 0) begin p0v = 1'b1; p0a = 3'($urandom_range(0, 7)); p0d = 8'($urandom); end
            if (!p1v && $urandom_range(0, 2) == 0) begin p1v = 1'b1; p1a = 3'($urandom_range(0, 7)); p1d = 8'($urandom); end
            cycle(p0v, p0a, p0d, p1v, p1a, p1d, ($urandom_range(0, 29) == 0));
            if (m_r0) p0v = 1'b0;
            if (m_r1) p1v = 1'b0;
        end
        for (int n = 0; n < 12; n++) cycle(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            vectors++; if (tb_regs[i] !== m_regs[i]) begin miscompares++; $display("FAIL random_reg%0d: got %0d expected %0d", i, tb_regs[i], m_regs[i]); end
        end
    endtask

    initial begin
        RESET = 1'b1;
        drive_idle();
        model_reset();
        #2;
        test_reset();
        test_single_write();
        test_contention();
        test_same_addr();
        test_clear();
        test_clear_reset();
        test_clear_restart();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 Clock is CLK and reset is RESET; one clock, reset asynchronous and active-high.
REQ-002 CLK  input  1  sole clock; all state updates on posedge.
REQ-003 RESET  input  1  asynchronous, active-high; clears all state.
REQ-004 REQ0_VALID / REQ1_VALID  input  1  requester n presents a register write.
REQ-005 REQ0_ADDR / REQ1_ADDR  input  3  target register index.
REQ-006 REQ0_DATA / REQ1_DATA  input  8  write data.
REQ-007 REQ0_READY / REQ1_READY  output  1  combinational grant; transfer on posedge when VALID&READY.
REQ-008 CLR_START  input  1  single-cycle request to zero all 8 registers.
REQ-009 CLR_DONE  output  1  one-cycle pulse when the clear sweep completes.
REQ-010 WRITEENABLE  output  1  registered write strobe to the register file.
REQ-011 WRITEREG  output  3  registered write address.
REQ-012 WRITEDATA  output  8  registered write data.
REQ-013 BUSY  output  1  high while in CLEAR state.

Function
REQ-014 The FSM SHALL have two states: ARB (reset state) and CLEAR.
REQ-015 In ARB, a single valid requester SHALL see READY=1 in the same cycle.
REQ-016 In ARB, with both VALID high, grant SHALL go round-robin: the requester not granted last wins; the last-grant pointer resets to 1, so REQ0 wins the first contention.
REQ-017 The last-grant pointer SHALL update only on an accepted transfer.
REQ-018 At most one READY SHALL be high in any cycle.
REQ-019 A transfer accepted at posedge N SHALL drive WRITEENABLE=1, WRITEREG=ADDR, WRITEDATA=DATA for the cycle after N; the register file commits at posedge N+1 (latency 1, throughput 1 per cycle).
REQ-020 With no transfer accepted, WRITEENABLE SHALL be 0 next cycle; WRITEREG/WRITEDATA hold their last values.
REQ-021 Two requests to the same address SHALL be serialised in grant order, so the later grant's data is the final value.
REQ-022 CLR_START sampled high in ARB SHALL force both READY to 0 that cycle and move the FSM to CLEAR with the counter at 0.
REQ-023 In CLEAR, each cycle SHALL output WRITEENABLE=1, WRITEREG=counter, WRITEDATA=0, then increment the counter; after index 7 the FSM returns to ARB.
REQ-024 The sweep SHALL give exactly 8 consecutive write cycles, regs 0..7 in order.
REQ-025 CLR_DONE SHALL pulse for one cycle, coincident with the first ARB cycle after the sweep.
REQ-026 In CLEAR, READY SHALL be 0 and CLR_START SHALL be ignored; requesters hold VALID/ADDR/DATA until accepted.
REQ-027 The 3-bit counter SHALL never wrap mid-sweep; terminal count 7 ends CLEAR.

Reset
REQ-028 RESET high SHALL immediately give: state ARB, counter 0, last-grant 1, WRITEENABLE 0, WRITEREG 0, WRITEDATA 0, CLR_DONE 0, BUSY 0.
REQ-029 RESET during CLEAR SHALL abort the sweep with no further writes and no CLR_DONE pulse.
REQ-030 After RESET deasserts, normal arbitration SHALL resume on the first posedge.

Structure
REQ-031 Shared package cpu_pkg SHALL hold REG_ADDR_W=3, REG_DATA_W=8, NUM_REGS=8, and the FSM state encoding.
REQ-032 The two-way round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs req[1:0], advance; output gnt[1:0]).
REQ-033 The block SHALL connect directly to reg_file IN/INADDRESS/WRITE with no glue logic.

Verification
REQ-034 REQ0 only, addr 2, data 95 -> READY0 same cycle; next cycle WE=1, WRITEREG=2, WRITEDATA=95; reg 2 reads 95 after the following posedge.
REQ-035 Both valid for 4 cycles (REQ0 addr 1/28, REQ1 addr 4/6) -> grants 0,1,0,1; WE high 4 consecutive cycles.
REQ-036 Both valid, both addr 3 (REQ0 data 15, REQ1 data 50) -> writes 15 then 50; reg 3 final value 50.
REQ-037 CLR_START with REQ1 valid -> READY1=0; 8 cycles WE=1, WRITEREG 0..7, WRITEDATA 0, BUSY=1; CLR_DONE one cycle; then REQ1 granted.
REQ-038 RESET asserted mid-clear at WRITEREG=3 -> WE=0 at once, no CLR_DONE, state ARB, first contention after release goes to REQ0.
REQ-039 CLR_START pulsed again during CLEAR -> ignored; exactly 8 writes and one CLR_DONE.
